// File: rtl/loop_pkg.sv
// ----------------------------------------------------------------------------
// loop_pkg
// Shared types for the loop timer array.
//   chan_state_e : per-channel state (idle, counting, one-shot finished)
//   chan_mode_t  : latched mode bits of a channel (oneshot, hold)
// ----------------------------------------------------------------------------
package loop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } chan_state_e;

  typedef struct packed {
    logic oneshot;
    logic hold;
  } chan_mode_t;

  // Periodic, pulse-ack mode used by auto-started channels
  localparam chan_mode_t MODE_AUTO = '{oneshot: 1'b0, hold: 1'b0};

endpackage

// File: rtl/loop_timer_chan.sv
// ----------------------------------------------------------------------------
// loop_timer_chan
// One independent timer channel: state, down-counter, latched mode, ack and
// sticky overrun flag.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   wr          : an accepted configuration write targets this channel
//   wr_en       : 1 = (re)start counting, 0 = stop (go idle)
//   wr_period   : period P in cycles (0 is treated as 1)
//   wr_mode     : oneshot / hold mode bits for the write
//   ack_clr     : clears a held ack and the overrun flag
//   ack         : expiry indication (pulse or held, registered)
//   overrun     : sticky, set on a hold-mode expiry while ack is still 1
// ----------------------------------------------------------------------------
module loop_timer_chan
  import loop_pkg::*;
#(
  parameter int CNT_WIDTH      = 8,
  parameter int DEFAULT_PERIOD = 15,
  parameter int AUTO_START     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 wr_en,
  input  logic [CNT_WIDTH-1:0] wr_period,
  input  chan_mode_t           wr_mode,
  input  logic                 ack_clr,
  output logic                 ack,
  output logic                 overrun
);

  // Counter reload value for a period: P-1, with P=0 folded onto P=1
  function automatic logic [CNT_WIDTH-1:0] reload_of(input logic [CNT_WIDTH-1:0] p);
    if (p == {CNT_WIDTH{1'b0}}) begin
      reload_of = {CNT_WIDTH{1'b0}};
    end else begin
      reload_of = p - CNT_WIDTH'(1);
    end
  endfunction

  localparam logic [CNT_WIDTH-1:0] RST_RELOAD =
    (DEFAULT_PERIOD <= 1) ? {CNT_WIDTH{1'b0}} : CNT_WIDTH'(DEFAULT_PERIOD - 1);
  localparam chan_state_e RST_STATE = (AUTO_START != 0) ? ST_COUNT : ST_IDLE;

  chan_state_e          state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] reload_r;
  chan_mode_t           mode_r;
  logic                 ack_r;
  logic                 ovr_r;
  logic                 expire_s;
  logic                 ovr_set_s;

  // A write on the same edge discards the expiry
  assign expire_s  = (state_r == ST_COUNT) && (cnt_r == {CNT_WIDTH{1'b0}}) && !wr;
  // A coincident clear lets the expiry win without flagging an overrun
  assign ovr_set_s = expire_s && mode_r.hold && ack_r && !ack_clr;

  // Channel state machine, down-counter and latched mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= RST_STATE;
      cnt_r    <= RST_RELOAD;
      reload_r <= RST_RELOAD;
      mode_r   <= MODE_AUTO;
    end else if (wr) begin
      if (wr_en) begin
        state_r  <= ST_COUNT;
        cnt_r    <= reload_of(wr_period);
        reload_r <= reload_of(wr_period);
        mode_r   <= wr_mode;
      end else begin
        state_r  <= ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_COUNT: begin
          if (cnt_r == {CNT_WIDTH{1'b0}}) begin
            if (mode_r.oneshot) begin
              state_r <= ST_DONE;
            end else begin
              cnt_r <= reload_r;
            end
          end else begin
            cnt_r <= cnt_r - CNT_WIDTH'(1);
          end
        end
        ST_IDLE, ST_DONE: begin
          state_r <= state_r;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Expiry indication and sticky overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r <= 1'b0;
      ovr_r <= 1'b0;
    end else begin
      if (wr) begin
        ack_r <= 1'b0;
      end else if (expire_s) begin
        ack_r <= 1'b1;
      end else if (mode_r.hold && !ack_clr) begin
        ack_r <= ack_r;
      end else begin
        ack_r <= 1'b0;
      end

      if (ovr_set_s) begin
        ovr_r <= 1'b1;
      end else if (ack_clr) begin
        ovr_r <= 1'b0;
      end else begin
        ovr_r <= ovr_r;
      end
    end
  end

  assign ack     = ack_r;
  assign overrun = ovr_r;

endmodule

// File: rtl/loop_timer_array.sv
// ----------------------------------------------------------------------------
// loop_timer_array
// Array of CHANNELS independent loop timers behind one configuration port.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   cfg_valid    : configuration write offered
//   cfg_ready    : write can be accepted (low in the cycle after an accept)
//   cfg_chan     : target channel
//   cfg_period   : period P in cycles
//   cfg_en       : 1 start/restart, 0 stop
//   cfg_oneshot  : 1 expire once, 0 periodic
//   cfg_hold     : 1 ack held until ack_clr, 0 one-cycle ack pulse
//   ack          : per-channel expiry indication
//   ack_clr      : per-channel clear of held ack and overrun
//   overrun      : per-channel sticky overrun flag
// ----------------------------------------------------------------------------
module loop_timer_array
  import loop_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int CNT_WIDTH      = 8,
  parameter int DEFAULT_PERIOD = 15,
  parameter int AUTO_START     = 1,
  localparam int CHAN_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic                 cfg_en,
  input  logic                 cfg_oneshot,
  input  logic                 cfg_hold,
  output logic [CHANNELS-1:0]  ack,
  input  logic [CHANNELS-1:0]  ack_clr,
  output logic [CHANNELS-1:0]  overrun
);

  logic                ready_r;
  logic                accept_s;
  logic [CHANNELS-1:0] wr_s;
  chan_mode_t          wr_mode_s;

  assign accept_s          = cfg_valid && ready_r;
  assign wr_mode_s.oneshot = cfg_oneshot;
  assign wr_mode_s.hold    = cfg_hold;

  // Write throttle: ready drops for exactly one cycle after each accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= !accept_s;
    end
  end

  // One-hot write decode; out-of-range channel numbers select nothing
  always_comb begin
    wr_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHAN_W'(i)) begin
        wr_s[i] = accept_s;
      end else begin
        wr_s[i] = 1'b0;
      end
    end
  end

  assign cfg_ready = ready_r;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    loop_timer_chan #(
      .CNT_WIDTH      (CNT_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .AUTO_START     (AUTO_START)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .wr        (wr_s[gi]),
      .wr_en     (cfg_en),
      .wr_period (cfg_period),
      .wr_mode   (wr_mode_s),
      .ack_clr   (ack_clr[gi]),
      .ack       (ack[gi]),
      .overrun   (overrun[gi])
    );
  end

endmodule

// File: tb/tb_loop_timer_array.sv
module tb_loop_timer_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_chan = 2'd0;
  logic [7:0] cfg_period = 8'd0;
  logic       cfg_en = 1'b0;
  logic       cfg_oneshot = 1'b0;
  logic       cfg_hold = 1'b0;
  logic [3:0] ack;
  logic [3:0] ack_clr = 4'b0000;
  logic [3:0] overrun;

  always #5 clk = ~clk;

  loop_timer_array #(
    .CHANNELS       (4),
    .CNT_WIDTH      (8),
    .DEFAULT_PERIOD (15),
    .AUTO_START     (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_period  (cfg_period),
    .cfg_en      (cfg_en),
    .cfg_oneshot (cfg_oneshot),
    .cfg_hold    (cfg_hold),
    .ack         (ack),
    .ack_clr     (ack_clr),
    .overrun     (overrun)
  );

  typedef struct {
    int         sec;
    int         edge_n;
    logic       rdy;
    logic [3:0] ack;
    logic [3:0] ovr;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n = 0;
  int   sec = 0;
  logic prev_rdy = 1'b0;

  // Expected pulse schedule of channels in periodic pulse mode:
  // expiry on edges base+per, base+2*per, ...
  logic [3:0] on = 4'b0000;
  int         base[4];
  int         per[4];

  // Hand-derived ch0 expectations for edges 1546..1563 (index 0 = edge 1546)
  logic [0:17] d_ack0 = 18'b001111101111110000;
  logic [0:17] d_ovr0 = 18'b000011100000111100;

  function automatic string sec_name(input int s);
    case (s)
      0: return "reset";
      1: return "auto_periodic";
      2: return "ch1_p3_pulse";
      3: return "ch2_oneshot_hold";
      4: return "ch0_hold_overrun";
      5: return "ch3_restart";
      6: return "ch2_p1_hold";
      7: return "async_reset";
      8: return "after_rerelease";
      default: return "other";
    endcase
  endfunction

  // One clock edge; pushes the expected outputs for the following cycle
  task automatic tick(input logic [3:0] hack, input logic [3:0] hovr);
    exp_t       e;
    logic [3:0] sack;
    @(posedge clk);
    n++;
    #1;
    sack = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (on[c] && (n > base[c]) && (((n - base[c]) % per[c]) == 0)) sack[c] = 1'b1;
    end
    e.sec    = sec;
    e.edge_n = n;
    if (rst) begin
      e.rdy = 1'b0;
      e.ack = 4'b0000;
      e.ovr = 4'b0000;
    end else begin
      e.rdy = !(cfg_valid && prev_rdy);
      e.ack = sack | hack;
      e.ovr = hovr;
    end
    prev_rdy = e.rdy;
    sb_q.push_back(e);
  endtask

  task automatic idle_ticks(input int k);
    for (int i = 0; i < k; i++) tick(4'b0000, 4'b0000);
  endtask

  task automatic set_write(input logic [1:0] ch, input logic [7:0] p, input logic en,
                           input logic os, input logic hd);
    cfg_valid   = 1'b1;
    cfg_chan    = ch;
    cfg_period  = p;
    cfg_en      = en;
    cfg_oneshot = os;
    cfg_hold    = hd;
  endtask

  task automatic all_auto();
    on = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      base[c] = 0;
      per[c]  = 15;
    end
  endtask

  // Monitor: compare every cycle for which an expectation was queued
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if ((ack !== e.ack) || (overrun !== e.ovr) || (cfg_ready !== e.rdy)) begin
          miscompares++;
          $display("FAIL %s edge %0d: ack=%b overrun=%b cfg_ready=%b, expected ack=%b overrun=%b cfg_ready=%b",
                   sec_name(e.sec), e.edge_n, ack, overrun, cfg_ready, e.ack, e.ovr, e.rdy);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      base[c] = 0;
      per[c]  = 15;
    end

    // Outputs held at reset values while rst is high
    sec = 0;
    idle_ticks(3);
    rst = 1'b0;
    n = 0;
    all_auto();

    // No writes: every channel pulses on edges 15, 30, ... 1500
    sec = 1;
    idle_ticks(1500);

    // ch1 P=3 periodic pulse, accepted on edge 1501
    sec = 2;
    set_write(2'd1, 8'd3, 1'b1, 1'b0, 1'b0);
    base[1] = n + 1;
    per[1]  = 3;
    tick(4'b0000, 4'b0000);
    cfg_valid = 1'b0;
    idle_ticks(19);

    // ch2 P=5 oneshot hold on edge 1521: ack after 1526..1528, cleared at 1529
    sec = 3;
    set_write(2'd2, 8'd5, 1'b1, 1'b1, 1'b1);
    on[2] = 1'b0;
    tick(4'b0000, 4'b0000);
    cfg_valid = 1'b0;
    idle_ticks(4);
    for (int i = 0; i < 3; i++) tick(4'b0100, 4'b0000);
    ack_clr = 4'b0100;
    tick(4'b0000, 4'b0000);
    ack_clr = 4'b0000;
    idle_ticks(16);

    // ch0 P=2 periodic hold on edge 1546: overrun, clears, clear-vs-expiry, stop
    sec = 4;
    on[0] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      ack_clr = ((i == 7) || (i == 10) || (i == 16)) ? 4'b0001 : 4'b0000;
      if (i == 0)  set_write(2'd0, 8'd2, 1'b1, 1'b0, 1'b1);
      if (i == 14) set_write(2'd0, 8'd2, 1'b0, 1'b0, 1'b1);
      tick({3'b000, d_ack0[i]}, {3'b000, d_ovr0[i]});
      cfg_valid = 1'b0;
      ack_clr   = 4'b0000;
    end

    // ch3 P=10 on edge 1565, rewritten P=4 on edge 1570: acks 1574, 1578, none at 1575
    sec = 5;
    idle_ticks(1);
    set_write(2'd3, 8'd10, 1'b1, 1'b0, 1'b0);
    base[3] = n + 1;
    per[3]  = 10;
    tick(4'b0000, 4'b0000);
    cfg_valid = 1'b0;
    idle_ticks(4);
    set_write(2'd3, 8'd4, 1'b1, 1'b0, 1'b0);
    base[3] = n + 1;
    per[3]  = 4;
    tick(4'b0000, 4'b0000);
    cfg_valid = 1'b0;
    idle_ticks(9);

    // ch2 P=1 periodic hold on edge 1580: ack from 1581, overrun from 1582
    sec = 6;
    set_write(2'd2, 8'd1, 1'b1, 1'b0, 1'b1);
    tick(4'b0000, 4'b0000);
    cfg_valid = 1'b0;
    tick(4'b0100, 4'b0000);
    for (int i = 0; i < 4; i++) tick(4'b0100, 4'b0100);

    // Asynchronous reset between edges: outputs drop before the next edge
    sec = 7;
    @(posedge clk);
    n++;
    #2;
    rst = 1'b1;
    e.sec = sec; e.edge_n = n; e.rdy = 1'b0; e.ack = 4'b0000; e.ovr = 4'b0000;
    prev_rdy = 1'b0;
    sb_q.push_back(e);
    idle_ticks(2);
    rst = 1'b0;
    n = 0;
    all_auto();

    // Timing restarts from the release
    sec = 8;
    idle_ticks(31);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
